// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encodings and defaults.
package uart_tx_arbiter_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCEPT = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;

  localparam logic [3:0] CHAR_BITS_DEF = 4'd8;
  // Tx_en must stay low at least this long so the transmitter's edge detector re-arms.
  localparam int GAP_CYC_MIN = 2;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] jj;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    jj    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      jj = sum[IW-1:0];
      if (!found && req_i[jj]) begin
        found     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources; round-robin, packet-locked grants.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int         NUM_REQ     = 4,
  parameter logic [3:0] CHAR_BITS   = CHAR_BITS_DEF,
  parameter int         GAP_CYC     = 4,
  parameter int         TIMEOUT_CYC = 2000000
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic [NUM_REQ-1:0]   Req_valid,
  input  logic [8*NUM_REQ-1:0] Req_data,
  input  logic [NUM_REQ-1:0]   Req_last,
  output logic [NUM_REQ-1:0]   Req_ready,
  output logic [NUM_REQ-1:0]   Grant,
  output logic                 Tx_en,
  output logic [7:0]           Message_out,
  output logic [3:0]           N_bits_out,
  input  logic                 Tx_done_in,
  output logic                 Busy,
  output logic                 Timeout_err
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int TW    = $clog2(TIMEOUT_CYC+1);
  localparam int GAP_N = (GAP_CYC < GAP_CYC_MIN) ? GAP_CYC_MIN : GAP_CYC;
  localparam int GW    = $clog2(GAP_N+1);

  logic [2:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic               lock_q, lock_d;
  logic [7:0]         msg_q, msg_d;
  logic               last_q, last_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [GW-1:0]      gcnt_q, gcnt_d;
  logic [1:0]         sync_q;
  logic               done_prev_q;
  logic               done_pulse;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic [NUM_REQ-1:0] ready;
  logic               timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (Req_valid),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Tx_done comes from the Tick domain; only a fresh rising edge marks a byte complete.
  assign done_pulse = sync_q[1] & ~done_prev_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    msg_d   = msg_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    ready   = '0;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!lock_q && arb_any) begin
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
          lock_d  = 1'b1;
          state_d = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (Req_valid[gidx_q]) begin
          ready   = grant_q;
          msg_d   = Req_data[{gidx_q, 3'b000} +: 8];
          last_d  = Req_last[gidx_q];
          state_d = ST_START;
        end
      end
      ST_START: begin
        tcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_pulse) begin
          gcnt_d  = '0;
          state_d = ST_GAP;
        end else if (tcnt_q == TW'(TIMEOUT_CYC-1)) begin
          // Abandon the rest of the packet so a stuck transmitter cannot hold the grant.
          timeout = 1'b1;
          last_d  = 1'b1;
          gcnt_d  = '0;
          state_d = ST_GAP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gcnt_q == GW'(GAP_N-1)) begin
          if (last_q) begin
            rr_d    = (gidx_q == IW'(NUM_REQ-1)) ? '0 : gidx_q + 1'b1;
            grant_d = '0;
            lock_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ACCEPT;
          end
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_q        <= '0;
      lock_q      <= 1'b0;
      msg_q       <= '0;
      last_q      <= 1'b0;
      tcnt_q      <= '0;
      gcnt_q      <= '0;
      sync_q      <= '0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      msg_q       <= msg_d;
      last_q      <= last_d;
      tcnt_q      <= tcnt_d;
      gcnt_q      <= gcnt_d;
      sync_q      <= {sync_q[0], Tx_done_in};
      done_prev_q <= sync_q[1];
    end
  end

  assign Req_ready   = ready;
  assign Grant       = grant_q;
  assign Tx_en       = (state_q == ST_START);
  assign Message_out = msg_q;
  assign N_bits_out  = CHAR_BITS;
  assign Busy        = (state_q != ST_IDLE);
  assign Timeout_err = timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural 16-Tick/bit transmitter model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic [NR-1:0] Req_valid = '0;
  logic [8*NR-1:0] Req_data = '0;
  logic [NR-1:0] Req_last = '0;
  logic [NR-1:0] Req_ready;
  logic [NR-1:0] Grant;
  logic          Tx_en;
  logic [7:0]    Message_out;
  logic [3:0]    N_bits_out;
  logic          Tx_done_in = 1'b0;
  logic          Busy;
  logic          Timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYC(4), .TIMEOUT_CYC(64)) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .Req_valid   (Req_valid),
    .Req_data    (Req_data),
    .Req_last    (Req_last),
    .Req_ready   (Req_ready),
    .Grant       (Grant),
    .Tx_en       (Tx_en),
    .Message_out (Message_out),
    .N_bits_out  (N_bits_out),
    .Tx_done_in  (Tx_done_in),
    .Busy        (Busy),
    .Timeout_err (Timeout_err)
  );

  always #5 Clock = ~Clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: Tick runs 5x Clock, 10 bits x 16 Ticks per character.
  logic       tick = 1'b0;
  logic       uart_on = 1'b1;
  logic       en_q = 1'b0;
  logic       ubusy = 1'b0;
  int         ucnt = 0;
  logic [7:0] ubyte = '0;
  logic [7:0] line_log[$];

  always #1 tick = ~tick;

  always @(posedge tick) begin
    en_q <= Tx_en;
    if (Tx_en && !en_q) begin
      Tx_done_in <= 1'b0;
      ubusy      <= uart_on;
      ucnt       <= 0;
      ubyte      <= Message_out;
    end else if (ubusy) begin
      if (ucnt == 159) begin
        ubusy      <= 1'b0;
        Tx_done_in <= 1'b1;
        line_log.push_back(ubyte);
      end else begin
        ucnt <= ucnt + 1;
      end
    end
  end

  function automatic logic [7:0] line_at(input int i);
    return (i < line_log.size()) ? line_log[i] : 8'hxx;
  endfunction

  // Requesters: one queue of {last, byte} each, popped on the cycle Req_ready was seen.
  logic [8:0]    rq[NR][$];
  logic [NR-1:0] hold = '0;
  logic [NR-1:0] rdy_seen = '0;
  int            cyc = 0;
  int            v0_cyc = 0;
  logic          v0_prev = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  always begin
    @(posedge Clock);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (rdy_seen[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (rq[i].size() > 0 && !hold[i]) begin
        Req_valid[i]       = 1'b1;
        Req_data[8*i +: 8] = rq[i][0][7:0];
        Req_last[i]        = rq[i][0][8];
      end else begin
        Req_valid[i] = 1'b0;
        Req_last[i]  = 1'b0;
      end
    end
    if (Req_valid[0] && !v0_prev) v0_cyc = cyc;
    v0_prev = Req_valid[0];
  end

  int txen_cnt = 0;
  int txq[$];
  int to_cnt = 0;
  int to_cyc = 0;
  int rdy0_cyc = 0;
  int g1_early = 0;
  logic watch_g1 = 1'b0;

  always @(negedge Clock) begin
    rdy_seen <= Req_ready;
    if (Reset_n) begin
      chk("rdy_in_grant", 32'(Req_ready & ~Grant), 32'd0);
      chk("rdy_onehot", 32'($onehot0(Req_ready)), 32'd1);
    end
    if (Tx_en) begin
      txen_cnt <= txen_cnt + 1;
      txq.push_back(cyc);
    end
    if (Timeout_err) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
    if (Req_ready[0]) rdy0_cyc <= cyc;
    if (watch_g1 && Grant[1] && line_log.size() < 4) g1_early <= g1_early + 1;
  end

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag);
    int b = 0;
    while (!(all_empty() && Req_valid == '0 && !Busy) && b < 2000) begin
      @(negedge Clock);
      b++;
    end
    chk(tag, 32'(b < 2000), 32'd1);
  endtask

  task automatic wait_txen(input int n, input string tag);
    int b = 0;
    while (txen_cnt < n && b < 500) begin
      @(negedge Clock);
      b++;
    end
    chk(tag, 32'(b < 500), 32'd1);
  endtask

  initial begin
    int nt;
    int b;
    logic [7:0] exp4[4];

    // Reset state
    repeat (3) @(negedge Clock);
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_txen", 32'(Tx_en), 32'd0);
    chk("rst_msg", 32'(Message_out), 32'd0);
    chk("rst_ready", 32'(Req_ready), 32'd0);
    chk("rst_tout", 32'(Timeout_err), 32'd0);
    chk("nbits", 32'(N_bits_out), 32'd8);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clock);

    // 1: single-byte packet, latency and hold of Message_out
    rq[0].push_back({1'b1, 8'hA5});
    wait_txen(1, "t1_txen_wait");
    chk("t1_valid_to_ready", 32'(rdy0_cyc - v0_cyc), 32'd1);
    chk("t1_ready_to_txen", 32'(txq[0] - rdy0_cyc), 32'd1);
    repeat (10) @(negedge Clock);
    chk("t1_msg_held", 32'(Message_out), 32'hA5);
    chk("t1_busy", 32'(Busy), 32'd1);
    wait_idle("t1_idle_wait");
    chk("t1_grant_free", 32'(Grant), 32'd0);
    chk("t1_line", 32'(line_at(0)), 32'hA5);
    chk("t1_txen_cnt", 32'(txen_cnt), 32'd1);

    // 2: 3-byte packet from Req0 with Req1 waiting
    rq[0].push_back({1'b0, 8'h11});
    rq[0].push_back({1'b0, 8'h22});
    rq[0].push_back({1'b1, 8'h33});
    b = 0;
    while (Grant != 4'b0001 && b < 100) begin @(negedge Clock); b++; end
    chk("t2_grant0", 32'(Grant), 32'h1);
    rq[1].push_back({1'b1, 8'h44});
    watch_g1 = 1'b1;
    wait_idle("t2_idle_wait");
    watch_g1 = 1'b0;
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) chk("t2_order", 32'(line_at(1 + k)), 32'(exp4[k]));
    chk("t2_g1_early", 32'(g1_early), 32'd0);

    // 3: all four at once, rr=2 -> 2,3,0,1 twice
    for (int i = 0; i < NR; i++) rq[i].push_back({1'b1, 8'hB0 + 8'(i)});
    wait_idle("t3a_idle_wait");
    exp4 = '{8'hB2, 8'hB3, 8'hB0, 8'hB1};
    for (int k = 0; k < 4; k++) chk("t3a_order", 32'(line_at(5 + k)), 32'(exp4[k]));
    for (int i = 0; i < NR; i++) rq[i].push_back({1'b1, 8'hC0 + 8'(i)});
    wait_idle("t3b_idle_wait");
    exp4 = '{8'hC2, 8'hC3, 8'hC0, 8'hC1};
    for (int k = 0; k < 4; k++) chk("t3b_order", 32'(line_at(9 + k)), 32'(exp4[k]));

    // 4: transmitter never finishes the byte -> timeout, next requester served
    nt = txen_cnt;
    uart_on = 1'b0;
    rq[2].push_back({1'b1, 8'hD2});
    rq[3].push_back({1'b1, 8'hE3});
    b = 0;
    while (to_cnt == 0 && b < 300) begin @(negedge Clock); b++; end
    chk("t4_timeout_seen", 32'(to_cnt), 32'd1);
    uart_on = 1'b1;
    chk("t4_timeout_delay", 32'(to_cyc - txq[nt]), 32'd64);
    wait_idle("t4_idle_wait");
    chk("t4_txen_cnt", 32'(txen_cnt - nt), 32'd2);
    chk("t4_line", 32'(line_at(13)), 32'hE3);
    chk("t4_log_size", 32'(line_log.size()), 32'd14);
    chk("t4_timeout_once", 32'(to_cnt), 32'd1);

    // 5: reset in the middle of a byte
    nt = txen_cnt;
    rq[0].push_back({1'b1, 8'h3C});
    wait_txen(nt + 1, "t5_txen_wait");
    repeat (5) @(negedge Clock);
    chk("t5_busy_before", 32'(Busy), 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(Grant), 32'd0);
    chk("t5_rst_busy", 32'(Busy), 32'd0);
    chk("t5_rst_msg", 32'(Message_out), 32'd0);
    chk("t5_rst_txen", 32'(Tx_en), 32'd0);
    chk("t5_rst_ready", 32'(Req_ready), 32'd0);
    repeat (3) @(negedge Clock);
    Reset_n = 1'b1;
    rq[1].push_back({1'b1, 8'h5A});
    b = 0;
    while (Grant == '0 && b < 100) begin @(negedge Clock); b++; end
    chk("t5_grant1", 32'(Grant), 32'h2);
    wait_idle("t5_idle_wait");
    chk("t5_line", 32'(line_at(14)), 32'h5A);
    chk("t5_log_size", 32'(line_log.size()), 32'd15);

    // 6: locked owner stalls mid-packet; nobody else is served meanwhile
    rq[2].push_back({1'b0, 8'h61});
    rq[2].push_back({1'b0, 8'h62});
    rq[2].push_back({1'b1, 8'h63});
    b = 0;
    while (line_log.size() < 16 && b < 300) begin @(negedge Clock); b++; end
    chk("t6_first_byte", 32'(line_at(15)), 32'h61);
    hold[2] = 1'b1;
    rq[0].push_back({1'b1, 8'h70});
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      chk("t6_grant_locked", 32'(Grant), 32'h4);
      chk("t6_no_ready0", 32'(Req_ready[0]), 32'd0);
    end
    hold[2] = 1'b0;
    wait_idle("t6_idle_wait");
    exp4 = '{8'h61, 8'h62, 8'h63, 8'h70};
    for (int k = 0; k < 4; k++) chk("t6_order", 32'(line_at(15 + k)), 32'(exp4[k]));
    chk("t6_grant_free", 32'(Grant), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
